// File: rtl/run_continue_ctrl.sv
// run_continue_ctrl: operator-button front end for the SLC-3.
// Synchronizes and debounces the active-low Run/Continue buttons, turns
// accepted presses into one-cycle strobes and runs the PAUSE/Continue
// handshake with the CPU control FSM, latching the pause code onto LED.
module run_continue_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LED_W           = 12
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             Continue,
    input  logic             pause_req,
    input  logic [LED_W-1:0] pause_code,
    output logic             run_pulse,
    output logic             cont_pulse,
    output logic [LED_W-1:0] LED,
    output logic             running
);

    // Counter value at which a persistent disagreement is accepted.
    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_RUN        = 2'd1,
        S_PAUSED     = 2'd2,
        S_WAIT_CLEAR = 2'd3
    } state_t;

    // Bit 0 is Run, bit 1 is Continue.
    logic [1:0] btn_raw;
    logic [1:0] press;

    assign btn_raw = {Continue, Run};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic        sync1_reg;
            logic        sync2_reg;
            logic        level_reg;
            logic [15:0] cnt_reg;

            // Two-flop synchronizer followed by the consecutive-sample debouncer.
            always_ff @(posedge Clk) begin
                if (Reset) begin
                    sync1_reg <= 1'b1;
                    sync2_reg <= 1'b1;
                    level_reg <= 1'b1;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= btn_raw[gi];
                    sync2_reg <= sync1_reg;
                    if (sync2_reg == level_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        level_reg <= sync2_reg;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
            end

            // A press is the debounced level about to flip from released to
            // pressed; flagging it one step early lets the FSM register its
            // strobe on the same edge the level flips.
            assign press[gi] = level_reg && !sync2_reg && (cnt_reg == CNT_LAST);
        end
    endgenerate

    state_t             state_reg, state_next;
    logic               run_pulse_reg, run_pulse_next;
    logic               cont_pulse_reg, cont_pulse_next;
    logic [LED_W-1:0]   led_reg, led_next;

    // State register together with the registered strobes and LED latch.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg      <= S_IDLE;
            run_pulse_reg  <= 1'b0;
            cont_pulse_reg <= 1'b0;
            led_reg        <= '0;
        end else begin
            state_reg      <= state_next;
            run_pulse_reg  <= run_pulse_next;
            cont_pulse_reg <= cont_pulse_next;
            led_reg        <= led_next;
        end
    end

    // Next-state logic: each state only reacts to the press that is valid there.
    always_comb begin
        state_next      = state_reg;
        run_pulse_next  = 1'b0;
        cont_pulse_next = 1'b0;
        led_next        = led_reg;
        case (state_reg)
            S_IDLE: begin
                if (press[0]) begin
                    run_pulse_next = 1'b1;
                    state_next     = S_RUN;
                end
            end
            S_RUN: begin
                if (pause_req) begin
                    led_next   = pause_code;
                    state_next = S_PAUSED;
                end
            end
            S_PAUSED: begin
                if (press[1]) begin
                    cont_pulse_next = 1'b1;
                    state_next      = S_WAIT_CLEAR;
                end else if (!pause_req) begin
                    state_next = S_RUN;
                end
            end
            S_WAIT_CLEAR: begin
                // Wait for the CPU to leave PAUSE so one press frees one pause.
                if (!pause_req) begin
                    state_next = S_RUN;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Output decode: running is a function of the registered state only.
    always_comb begin
        running    = (state_reg != S_IDLE);
        run_pulse  = run_pulse_reg;
        cont_pulse = cont_pulse_reg;
        LED        = led_reg;
    end

endmodule

// File: tb/tb_run_continue_ctrl.sv
// Self-checking bench for run_continue_ctrl: directed scenarios followed by
// random button/pause activity, compared every cycle with a behavioural model.
module tb_run_continue_ctrl;

    localparam int N = 4;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Run = 1'b1;
    logic        Continue = 1'b1;
    logic        pause_req = 1'b0;
    logic [11:0] pause_code = 12'h000;
    logic        run_pulse;
    logic        cont_pulse;
    logic [11:0] LED;
    logic        running;

    int total = 0;
    int bad = 0;
    int cnt_run = 0;
    int cnt_cont = 0;

    // Behavioural model: a button sample is the raw level from two edges ago;
    // the debounced level changes when the last N samples all disagree with it.
    bit dly[2][2];
    bit win[2][N];
    bit lvl[2];
    int m_state;          // 0 idle, 1 running, 2 paused, 3 waiting for pause_req low
    bit e_run, e_cont;
    logic [11:0] e_led;

    run_continue_ctrl #(.DEBOUNCE_CYCLES(N), .LED_W(12)) dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
        .pause_req(pause_req), .pause_code(pause_code),
        .run_pulse(run_pulse), .cont_pulse(cont_pulse),
        .LED(LED), .running(running)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit rst, input bit raw_run, input bit raw_cont,
                              input bit preq, input logic [11:0] code);
        bit raw[2];
        bit pr[2];
        bit s;
        bit all_diff;
        raw[0] = raw_run;
        raw[1] = raw_cont;
        e_run  = 1'b0;
        e_cont = 1'b0;
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                dly[b][0] = 1'b1;
                dly[b][1] = 1'b1;
                for (int i = 0; i < N; i++) win[b][i] = 1'b1;
                lvl[b] = 1'b1;
            end
            m_state = 0;
            e_led   = 12'h000;
            return;
        end
        for (int b = 0; b < 2; b++) begin
            s = dly[b][1];
            dly[b][1] = dly[b][0];
            dly[b][0] = raw[b];
            for (int i = N - 1; i > 0; i--) win[b][i] = win[b][i-1];
            win[b][0] = s;
            all_diff = 1'b1;
            for (int i = 0; i < N; i++) if (win[b][i] == lvl[b]) all_diff = 1'b0;
            pr[b] = all_diff && lvl[b];
            if (all_diff) lvl[b] = ~lvl[b];
        end
        case (m_state)
            0: if (pr[0]) begin e_run = 1'b1; m_state = 1; end
            1: if (preq) begin e_led = code; m_state = 2; end
            2: if (pr[1]) begin e_cont = 1'b1; m_state = 3; end
               else if (!preq) m_state = 1;
            default: if (!preq) m_state = 1;
        endcase
    endtask

    // One clock: model follows the inputs seen at the edge, outputs checked 1 time unit later.
    task automatic tick();
        bit r, rr, rc, pq;
        logic [11:0] pc;
        r = Reset; rr = Run; rc = Continue; pq = pause_req; pc = pause_code;
        @(posedge Clk);
        model_edge(r, rr, rc, pq, pc);
        #1;
        check("running", 32'(running), 32'(m_state != 0));
        check("run_pulse", 32'(run_pulse), 32'(e_run));
        check("cont_pulse", 32'(cont_pulse), 32'(e_cont));
        check("led", 32'(LED), 32'(e_led));
        check("pulse_excl", 32'(run_pulse & cont_pulse), 32'd0);
        if (run_pulse === 1'b1) cnt_run++;
        if (cont_pulse === 1'b1) cnt_cont++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        // Reset held two cycles with buttons released.
        ticks(2);
        check("rst_led", 32'(LED), 32'h000);
        check("rst_running", 32'(running), 32'd0);
        Reset = 1'b0;
        ticks(5);
        check("idle_running", 32'(running), 32'd0);
        $display("reset: running=%0b LED=%03h", running, LED);

        // Short Run glitch must be filtered.
        Run = 1'b0; ticks(3);
        Run = 1'b1; ticks(8);
        check("glitch_run_cnt", 32'(cnt_run), 32'd0);
        check("glitch_running", 32'(running), 32'd0);
        $display("glitch: run pulses=%0d running=%0b", cnt_run, running);

        // Clean Run press of 10 cycles.
        Run = 1'b0; ticks(10);
        Run = 1'b1; ticks(8);
        check("run_cnt", 32'(cnt_run), 32'd1);
        check("run_running", 32'(running), 32'd1);
        $display("run press: run pulses=%0d running=%0b", cnt_run, running);

        // Continue held from before the pause must not resume.
        Continue = 1'b0; ticks(6);
        pause_req = 1'b1; pause_code = 12'h0A5; ticks(2);
        check("pause_led", 32'(LED), 32'h0A5);
        ticks(5);
        check("held_cont_cnt", 32'(cnt_cont), 32'd0);
        Continue = 1'b1; ticks(8);
        Continue = 1'b0; ticks(10);
        Continue = 1'b1; ticks(8);
        check("fresh_cont_cnt", 32'(cnt_cont), 32'd1);
        $display("pause 0A5: LED=%03h cont pulses=%0d", LED, cnt_cont);

        // Second press while pause_req still high is not honoured.
        Continue = 1'b0; ticks(10);
        Continue = 1'b1; ticks(8);
        check("second_cont_cnt", 32'(cnt_cont), 32'd1);
        pause_req = 1'b0; ticks(3);
        check("resume_running", 32'(running), 32'd1);
        pause_req = 1'b1; pause_code = 12'h3FF; ticks(2);
        check("pause2_led", 32'(LED), 32'h3FF);
        Continue = 1'b0; ticks(10);
        Continue = 1'b1; ticks(8);
        check("pause2_cont_cnt", 32'(cnt_cont), 32'd2);
        pause_req = 1'b0; ticks(3);
        $display("pause 3FF: LED=%03h cont pulses=%0d", LED, cnt_cont);

        // Reset while paused with Continue mid-debounce.
        pause_req = 1'b1; pause_code = 12'h123; ticks(3);
        Continue = 1'b0; ticks(3);
        Reset = 1'b1; ticks(2);
        Reset = 1'b0; ticks(10);
        check("rst_mid_cont_cnt", 32'(cnt_cont), 32'd2);
        check("rst_mid_led", 32'(LED), 32'h000);
        check("rst_mid_running", 32'(running), 32'd0);
        Continue = 1'b1; pause_req = 1'b0; ticks(8);
        $display("reset mid-handshake: running=%0b LED=%03h cont pulses=%0d", running, LED, cnt_cont);

        // Random activity against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0) Run = ~Run;
            if ($urandom_range(0, 5) == 0) Continue = ~Continue;
            if ($urandom_range(0, 11) == 0) pause_req = ~pause_req;
            pause_code = 12'($urandom);
            Reset = ($urandom_range(0, 499) == 0);
            tick();
        end
        $display("random: run pulses=%0d cont pulses=%0d", cnt_run, cnt_cont);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/run_continue_ctrl.md
Name: run_continue_ctrl

Overview:
- Receive-side front-end for the SLC-3 operator buttons.
- Synchronizes and debounces the active-low Run and Continue push-buttons, then converts each press into a single-cycle pulse.
- Runs the PAUSE/Continue handshake with the CPU control FSM and latches the pause code onto LED.
- Sits between the board buttons and the CPU core, beside the HEX drivers.

Parameters:
DEBOUNCE_CYCLES, 4, number of consecutive equal synchronized samples required to accept a new button level (range 1..2^16-1).
LED_W, 12, width of the pause code and LED output.

Ports:
Clk  input  1  system clock; all logic on rising edge
Reset  input  1  synchronous, active-high reset
Run  input  1  active-low Run button, asynchronous to Clk
Continue  input  1  active-low Continue button, asynchronous to Clk
pause_req  input  1  from CPU FSM; held high while the CPU sits in a PAUSE state
pause_code  input  LED_W  code from CPU (IR[11:0]); valid while pause_req is high
run_pulse  output  1  one-cycle start strobe to the CPU
cont_pulse  output  1  one-cycle resume strobe to the CPU
LED  output  LED_W  latched pause code
running  output  1  high in states RUN, PAUSED and WAIT_CLEAR

Behaviour:
- Reset (Reset=1 at an edge):
  - Synchronizer flops and debounced levels go to 1 (released); debounce counters go to 0.
  - FSM goes to IDLE; LED=0; run_pulse=0; cont_pulse=0; running=0.
  - Reset mid-handshake discards any pending press or pause.
- Synchronizer: two flops per button, with no combinational path from Run/Continue to any output.
- Debounce, per button:
  - If the synced sample equals the debounced level, counter=0.
  - Otherwise counter increments. When it reaches DEBOUNCE_CYCLES-1 and the sample still differs, the debounced level flips and counter=0.
  - Any return to the old level before the flip clears the counter.
- Press event: the debounced level goes 1->0, high for exactly one cycle. Release events generate nothing.
- Latency: a clean low applied before edge k produces a press event (and pulse, if accepted) visible after edge k+1+DEBOUNCE_CYCLES. Outputs are registered.
- FSM states and transitions:
  - IDLE: running=0. A Run press sets run_pulse=1 for one cycle and moves to RUN. Continue presses and pause_req are ignored.
  - RUN: running=1.
    - pause_req=1 latches pause_code into LED and moves to PAUSED, taking effect the same edge pause_req is sampled high.
    - Run and Continue presses are ignored.
  - PAUSED: LED holds.
    - A Continue press sets cont_pulse=1 for one cycle and moves to WAIT_CLEAR.
    - If pause_req drops with no press, move to RUN with no cont_pulse.
  - WAIT_CLEAR: no further cont_pulse. Move to RUN when pause_req=0.
    - A new pause_req must be seen low for at least one cycle before it is honoured again, so one press never releases two pauses.
- Edge-based acceptance: a Continue held down from before entering PAUSED does not resume. A fresh press is required.
- Simultaneous events:
  - Run and Continue presses in the same cycle: only the press valid for the current state acts.
  - A Continue press in the same cycle that RUN->PAUSED occurs is ignored.
- LED keeps the last pause code until the next pause or Reset.
- run_pulse and cont_pulse are never high in the same cycle.

Test Plan:
(All with DEBOUNCE_CYCLES=4.)
- Reset held 2 cycles, buttons high -> LED=0x000, running=0, no pulses; after release the FSM stays IDLE with no pulses.
- Run low for 10 cycles starting before edge k -> run_pulse=1 only in the cycle after edge k+5; running=1 thereafter; releasing Run produces nothing.
- Glitch: Run low for 3 cycles, then high -> no run_pulse, FSM stays IDLE.
- In RUN, pause_req=1 with pause_code=0x0A5 -> LED=0x0A5 next cycle. Continue held low from before the pause -> no cont_pulse. Release, then a new 10-cycle press -> exactly one cont_pulse. pause_req dropped 3 cycles later -> RUN.
- After cont_pulse, keep pause_req high 5 more cycles, then issue a second Continue press -> no second cont_pulse. Drop pause_req, then raise it with 0x3FF -> LED=0x3FF and a new press is accepted.
- Reset asserted while PAUSED with Continue mid-debounce -> after Reset: IDLE, LED=0, cont_pulse never asserted.
